// File: rtl/skew_gen.sv
// skew_gen: programmable pair of skewed pulse trains.
//
// On start (in idle) the block latches skew, pulse width, period, pulse count and lead
// select, then emits n_pulses pulse pairs. The lead output is high for the first W cycles
// of each period; the lag output is the same pulse delayed by skew cycles. The effective
// period is stretched when needed so that consecutive pulse pairs never overlap.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   start      launch request, honoured only in idle
//   abort      stop a running train immediately, without done
//   skew       lag delay in cycles (0 = coincident edges)
//   high_len   pulse width in cycles (0 treated as 1)
//   period     lead-rise to lead-rise spacing in cycles
//   n_pulses   pulse pairs per train
//   swap       0: clk1_o leads, 1: clk2_o leads
//   clk1_o     registered pulse output 1
//   clk2_o     registered pulse output 2
//   busy       high while a train is running
//   done       one-cycle completion pulse
//   pulse_idx  index of the current pulse pair
module skew_gen #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] skew,
    input  logic [CNT_W-1:0] high_len,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] n_pulses,
    input  logic             swap,
    output logic             clk1_o,
    output logic             clk2_o,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulse_idx
);

    // One extra bit so skew + W + 1 cannot overflow.
    localparam int unsigned PW = CNT_W + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    ph_q, ph_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] skew_q, skew_d;
    logic [CNT_W-1:0] w_q, w_d;
    logic [PW-1:0]    peff_q, peff_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic             swap_q, swap_d;
    logic             clk1_q, clk1_d;
    logic             clk2_q, clk2_d;
    logic             done_q, done_d;

    logic [CNT_W-1:0] w_in;
    logic [PW-1:0]    min_p;
    logic [PW-1:0]    peff_in;
    logic [PW-1:0]    lag_end;
    logic             lead_d;
    logic             lag_d;

    always_comb begin
        w_in    = (high_len == '0) ? CNT_W'(1) : high_len;
        min_p   = {1'b0, skew} + {1'b0, w_in} + PW'(1);
        peff_in = ({1'b0, period} > min_p) ? {1'b0, period} : min_p;

        state_d = state_q;
        ph_d    = ph_q;
        idx_d   = idx_q;
        skew_d  = skew_q;
        w_d     = w_q;
        peff_d  = peff_q;
        n_d     = n_q;
        swap_d  = swap_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A start coinciding with the done pulse is dropped.
                if (start && !done_q) begin
                    if (n_pulses == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        ph_d    = '0;
                        idx_d   = '0;
                        skew_d  = skew;
                        w_d     = w_in;
                        peff_d  = peff_in;
                        n_d     = n_pulses;
                        swap_d  = swap;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    ph_d    = '0;
                    idx_d   = '0;
                end else if (ph_q == peff_q - PW'(1)) begin
                    ph_d = '0;
                    if (idx_q == n_q - CNT_W'(1)) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + CNT_W'(1);
                    end
                end else begin
                    ph_d = ph_q + PW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from next-state values so the registers line up with ph.
        lag_end = {1'b0, skew_d} + {1'b0, w_d};
        lead_d  = (state_d == RUN) && (ph_d < {1'b0, w_d});
        lag_d   = (state_d == RUN) && (ph_d >= {1'b0, skew_d}) && (ph_d < lag_end);
        clk1_d  = swap_d ? lag_d : lead_d;
        clk2_d  = swap_d ? lead_d : lag_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ph_q    <= '0;
            idx_q   <= '0;
            skew_q  <= '0;
            w_q     <= '0;
            peff_q  <= '0;
            n_q     <= '0;
            swap_q  <= 1'b0;
            clk1_q  <= 1'b0;
            clk2_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            idx_q   <= idx_d;
            skew_q  <= skew_d;
            w_q     <= w_d;
            peff_q  <= peff_d;
            n_q     <= n_d;
            swap_q  <= swap_d;
            clk1_q  <= clk1_d;
            clk2_q  <= clk2_d;
            done_q  <= done_d;
        end
    end

    assign clk1_o    = clk1_q;
    assign clk2_o    = clk2_q;
    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign pulse_idx = idx_q;

endmodule

// File: tb/tb_skew_gen.sv
// Self-checking bench for skew_gen: directed scenarios plus randomized traffic, all checked
// against a cycle-count reference model (position within train, modulo effective period).
module tb_skew_gen;

    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] skew;
    logic [CNT_W-1:0] high_len;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] n_pulses;
    logic             swap;
    logic             clk1_o;
    logic             clk2_o;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pulse_idx;

    skew_gen #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .skew      (skew),
        .high_len  (high_len),
        .period    (period),
        .n_pulses  (n_pulses),
        .swap      (swap),
        .clk1_o    (clk1_o),
        .clk2_o    (clk2_o),
        .busy      (busy),
        .done      (done),
        .pulse_idx (pulse_idx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: t = cycles elapsed in the current train.
    bit m_run  = 0;
    bit m_done = 0;
    int m_t    = 0;
    int m_skew = 0;
    int m_w    = 0;
    int m_peff = 0;
    int m_n    = 0;
    bit m_swap = 0;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_edge();
        bit prev_done;
        prev_done = m_done;
        m_done    = 0;
        if (rst) begin
            m_run = 0; m_t = 0; m_skew = 0; m_w = 0; m_peff = 0; m_n = 0; m_swap = 0;
        end else if (m_run) begin
            if (abort) begin
                m_run = 0;
            end else if (m_t + 1 == m_n * m_peff) begin
                m_run  = 0;
                m_done = 1;
            end else begin
                m_t++;
            end
        end else if (start && !prev_done) begin
            if (n_pulses == 0) begin
                m_done = 1;
            end else begin
                m_run  = 1;
                m_t    = 0;
                m_skew = int'(skew);
                m_w    = (high_len == 0) ? 1 : int'(high_len);
                m_peff = (int'(period) > m_skew + m_w + 1) ? int'(period) : m_skew + m_w + 1;
                m_n    = int'(n_pulses);
                m_swap = swap;
            end
        end
    endtask

    task automatic step();
        int ph;
        bit lead;
        bit lag;
        @(posedge clk);
        model_edge();
        #1;
        ph   = m_run ? (m_t % m_peff) : 0;
        lead = m_run && (ph < m_w);
        lag  = m_run && (ph >= m_skew) && (ph < m_skew + m_w);
        check("clk1_o", clk1_o, m_swap ? lag : lead);
        check("clk2_o", clk2_o, m_swap ? lead : lag);
        check("busy", busy, m_run);
        check("done", done, m_done);
        check("pulse_idx", pulse_idx, m_run ? m_t / m_peff : 0);
    endtask

    task automatic set_cfg(input int s, input int h, input int p, input int n, input bit sw);
        skew     = CNT_W'(s);
        high_len = CNT_W'(h);
        period   = CNT_W'(p);
        n_pulses = CNT_W'(n);
        swap     = sw;
    endtask

    // Launch a train and count cycles until done; the launch cycle is T, first step is T+1.
    task automatic run_to_done(input string tag, input int exp_cycles);
        int k;
        start = 1'b1;
        step();
        start = 1'b0;
        k = 1;
        while (!done && k < 200) begin
            set_cfg($urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 20),
                    $urandom_range(0, 5), 1'($urandom));
            step();
            k++;
        end
        check(tag, k, exp_cycles);
        step();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        set_cfg(0, 0, 0, 0, 1'b0);
        step();
        step();
        rst = 1'b0;
        step();

        // Scenario 1 and its swapped twin.
        set_cfg(2, 3, 8, 2, 1'b0);
        run_to_done("scn1_done_at", 17);
        set_cfg(2, 3, 8, 2, 1'b1);
        run_to_done("scn2_done_at", 17);
        // Stretched period and zero-skew cases.
        set_cfg(6, 4, 5, 1, 1'b0);
        run_to_done("scn3_done_at", 12);
        set_cfg(0, 0, 3, 3, 1'b0);
        run_to_done("scn4_done_at", 10);

        // Scenario 5: abort mid-pulse of pair 1, then a fresh start is accepted.
        set_cfg(2, 3, 8, 2, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 40 && m_t != m_peff + 1; i++) step();
        check("scn5_mid_pulse", pulse_idx, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("scn5_abort_busy", busy, 0);
        set_cfg(1, 2, 4, 1, 1'b0);
        run_to_done("scn5_restart", 5);

        // Scenario 6: reset during run with start and abort high, then an empty train.
        set_cfg(3, 2, 6, 3, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1; start = 1'b1; abort = 1'b1;
        step();
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        check("scn6_rst_clk2", clk2_o, 0);
        set_cfg(3, 2, 6, 0, 1'b0);
        run_to_done("scn6_empty", 1);

        // Randomized traffic: config inputs churn every cycle, occasional abort and reset.
        for (int c = 0; c < 4000; c++) begin
            set_cfg($urandom_range(0, 12), $urandom_range(0, 5), $urandom_range(0, 16),
                    $urandom_range(0, 3), 1'($urandom));
            start = ($urandom_range(0, 5) == 0);
            abort = ($urandom_range(0, 63) == 0);
            rst   = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/skew_gen.md
SKEW_GEN -- requirements
Module: skew_gen

Interface
REQ-001 Parameter CNT_W, default 8, sets the width of every timing and count field.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to launch a pulse train; sampled only in IDLE.
REQ-005 abort  input  1  terminates a running train; synchronous.
REQ-006 skew  input  CNT_W  lag-edge delay after the lead edge, in clk cycles; 0 means coincident edges.
REQ-007 high_len  input  CNT_W  high width of each output pulse, in cycles; 0 is treated as 1.
REQ-008 period  input  CNT_W  lead-rise-to-lead-rise spacing, in cycles.
REQ-009 n_pulses  input  CNT_W  number of pulse pairs per train.
REQ-010 swap  input  1  0: clk1_o leads; 1: clk2_o leads.
REQ-011 clk1_o  output  1  skewed pulse output 1, registered.
REQ-012 clk2_o  output  1  skewed pulse output 2, registered.
REQ-013 busy  output  1  high while a train is running.
REQ-014 done  output  1  one-cycle pulse at train completion.
REQ-015 pulse_idx  output  CNT_W  index of the current pulse pair, starting at 0.

Function
REQ-016 States SHALL be IDLE and RUN.
REQ-017 In IDLE with start=1 at edge T, skew, high_len (clamped), period, n_pulses and swap SHALL be latched; later input changes SHALL NOT affect the running train.
REQ-018 Width rule: W = max(high_len,1); the phase counter SHALL be CNT_W+1 bits; P_eff = max(period, skew+W+1), computed without overflow.
REQ-019 For n_pulses>0, the block SHALL enter RUN at T+1 with phase counter ph=0, pulse_idx=0 and busy=1.
REQ-020 In RUN, the lead output SHALL be 1 iff ph<W.
REQ-021 In RUN, the lag output SHALL be 1 iff skew<=ph<skew+W, giving both outputs equal width W and a constant lag of skew cycles.
REQ-022 Outputs SHALL be registered, so the lead output is high on cycles T+1 through T+W.
REQ-023 ph SHALL increment each cycle and wrap to 0 at P_eff-1.
REQ-024 At each wrap, pulse_idx SHALL increment.
REQ-025 At the wrap where pulse_idx=n_pulses-1, the block SHALL return to IDLE, drive busy=0 and assert done for exactly one cycle.
REQ-026 For n_pulses=0 with start, the block SHALL stay in IDLE, keep outputs low and assert done at T+1 only.
REQ-027 start while in RUN SHALL be ignored; start asserted on the same cycle as done SHALL be ignored.
REQ-028 abort in RUN SHALL force IDLE, drive clk1_o=clk2_o=0, busy=0 and pulse_idx=0 on the next edge, with no done pulse.
REQ-029 abort has priority over a simultaneous final wrap.
REQ-030 abort in IDLE SHALL have no effect.
REQ-031 The skew=0 case SHALL produce identical waveforms on both outputs.
REQ-032 If skew>=period, P_eff SHALL stretch the period so the pulse pairs of consecutive periods never overlap.

Reset
REQ-033 rst=1 at any edge SHALL force IDLE with clk1_o=0, clk2_o=0, busy=0, done=0 and pulse_idx=0, and SHALL clear all latched config.
REQ-034 rst SHALL override start and abort.
REQ-035 rst during RUN SHALL truncate output pulses immediately at that edge and SHALL NOT assert done.

Verification
REQ-036 Scenario 1: skew=2, high_len=3, period=8, n_pulses=2, swap=0, start at T -> clk1_o high T+1..T+3 and T+9..T+11; clk2_o high T+3..T+5 and T+11..T+13; done at T+17; busy low from T+17.
REQ-037 Scenario 2: same configuration as Scenario 1 with swap=1 -> the clk1_o and clk2_o waveforms are exchanged.
REQ-038 Scenario 3: skew=6, high_len=4, period=5, n_pulses=1 -> P_eff=11; lead high T+1..T+4; lag high T+7..T+10; done at T+12.
REQ-039 Scenario 4: skew=0, high_len=0, period=3, n_pulses=3 -> both outputs are 1-cycle pulses at T+1, T+4 and T+7; done at T+10.
REQ-040 Scenario 5: abort at pulse_idx=1 mid-pulse -> outputs low on the next edge, no done; a new start is then accepted in IDLE.
REQ-041 Scenario 6: rst asserted in RUN while start=1 and abort=1 -> all outputs 0 next edge, no done; n_pulses=0 start afterwards -> done at T+1 with outputs low.
